// File: rtl/oc_collector.sv
// rtl/oc_collector.sv - operand collector bank: allocate, request RF rows, gather responses, dispatch
// Four entries cycle FREE -> REQ -> WAIT -> READY -> FREE; source-less instructions skip straight to READY.
module oc_collector #(
  parameter int DW     = 256,
  parameter int NUM_OC = 4,
  parameter int ROW_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [2:0]       alloc_warp,
  input  logic             alloc_src1_valid,
  input  logic             alloc_src2_valid,
  input  logic [ROW_W-1:0] alloc_src1_row,
  input  logic [ROW_W-1:0] alloc_src2_row,
  input  logic [ROW_W-1:0] alloc_dst_row,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_2op,
  output logic             req_src1_valid,
  output logic             req_src2_valid,
  output logic [ROW_W-1:0] req_src1_row,
  output logic [ROW_W-1:0] req_src2_row,
  output logic [2:0]       req_src1_tag,
  output logic [2:0]       req_src2_tag,
  input  logic             rsp_valid,
  input  logic [2:0]       rsp_tag,
  input  logic [DW-1:0]    rsp_data,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [1:0]       disp_ocid,
  output logic [2:0]       disp_warp,
  output logic [ROW_W-1:0] disp_dst_row,
  output logic [DW-1:0]    disp_src1_data,
  output logic [DW-1:0]    disp_src2_data,
  output logic             rsp_err
);

  typedef enum logic [1:0] {S_FREE, S_REQ, S_WAIT, S_READY} oc_state_t;

  oc_state_t        st      [NUM_OC];
  logic [2:0]       warp_q  [NUM_OC];
  logic [ROW_W-1:0] dst_q   [NUM_OC];
  logic [ROW_W-1:0] row1_q  [NUM_OC];
  logic [ROW_W-1:0] row2_q  [NUM_OC];
  logic             v1_q    [NUM_OC];
  logic             v2_q    [NUM_OC];
  logic             got1_q  [NUM_OC];
  logic             got2_q  [NUM_OC];
  logic [DW-1:0]    data1_q [NUM_OC];
  logic [DW-1:0]    data2_q [NUM_OC];

  logic [1:0] rr_ptr;
  logic       rsp_block;
  logic [1:0] alloc_idx, req_idx, disp_idx, rr_j;
  logic [1:0] rsp_ent;
  logic       rsp_src, rsp_ok, rsp_done;

  // Priority pickers: lowest index for alloc/request, round-robin from rr_ptr for dispatch.
  always_comb begin
    alloc_ready = 1'b0;
    alloc_idx   = '0;
    req_valid   = 1'b0;
    req_idx     = '0;
    disp_valid  = 1'b0;
    disp_idx    = '0;
    rr_j        = '0;
    for (int i = NUM_OC - 1; i >= 0; i--) begin
      if (st[i] == S_FREE) begin
        alloc_ready = 1'b1;
        alloc_idx   = 2'(i);
      end
      if (st[i] == S_REQ) begin
        req_valid = 1'b1;
        req_idx   = 2'(i);
      end
    end
    for (int k = NUM_OC - 1; k >= 0; k--) begin
      rr_j = rr_ptr + 2'(k);
      if (st[rr_j] == S_READY) begin
        disp_valid = 1'b1;
        disp_idx   = rr_j;
      end
    end
  end

  assign rsp_ent = rsp_tag[1:0];
  assign rsp_src = rsp_tag[2];

  // done counts the response being accepted this cycle as already received.
  always_comb begin
    rsp_ok   = 1'b0;
    rsp_done = 1'b0;
    if (st[rsp_ent] == S_WAIT) begin
      if (rsp_src) begin
        rsp_ok   = v2_q[rsp_ent] && !got2_q[rsp_ent];
        rsp_done = !v1_q[rsp_ent] || got1_q[rsp_ent];
      end else begin
        rsp_ok   = v1_q[rsp_ent] && !got1_q[rsp_ent];
        rsp_done = !v2_q[rsp_ent] || got2_q[rsp_ent];
      end
    end
  end

  assign req_src1_valid = req_valid && v1_q[req_idx];
  assign req_src2_valid = req_valid && v2_q[req_idx];
  assign req_2op        = req_src1_valid && req_src2_valid;
  assign req_src1_row   = req_src1_valid ? row1_q[req_idx] : '0;
  assign req_src2_row   = req_src2_valid ? row2_q[req_idx] : '0;
  assign req_src1_tag   = req_src1_valid ? {1'b0, req_idx} : 3'b000;
  assign req_src2_tag   = req_src2_valid ? {1'b1, req_idx} : 3'b000;

  assign disp_ocid      = disp_valid ? disp_idx : '0;
  assign disp_warp      = disp_valid ? warp_q[disp_idx] : '0;
  assign disp_dst_row   = disp_valid ? dst_q[disp_idx] : '0;
  assign disp_src1_data = (disp_valid && v1_q[disp_idx]) ? data1_q[disp_idx] : '0;
  assign disp_src2_data = (disp_valid && v2_q[disp_idx]) ? data2_q[disp_idx] : '0;

  // Each event touches an entry in a distinct state, so same-cycle updates never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OC; i++) begin
        st[i]      <= S_FREE;
        warp_q[i]  <= '0;
        dst_q[i]   <= '0;
        row1_q[i]  <= '0;
        row2_q[i]  <= '0;
        v1_q[i]    <= 1'b0;
        v2_q[i]    <= 1'b0;
        got1_q[i]  <= 1'b0;
        got2_q[i]  <= 1'b0;
        data1_q[i] <= '0;
        data2_q[i] <= '0;
      end
      rr_ptr    <= '0;
      rsp_err   <= 1'b0;
      rsp_block <= 1'b1;
    end else begin
      rsp_block <= 1'b0;
      if (alloc_valid && alloc_ready) begin
        warp_q[alloc_idx] <= alloc_warp;
        dst_q[alloc_idx]  <= alloc_dst_row;
        row1_q[alloc_idx] <= alloc_src1_row;
        row2_q[alloc_idx] <= alloc_src2_row;
        v1_q[alloc_idx]   <= alloc_src1_valid;
        v2_q[alloc_idx]   <= alloc_src2_valid;
        got1_q[alloc_idx] <= 1'b0;
        got2_q[alloc_idx] <= 1'b0;
        st[alloc_idx]     <= (alloc_src1_valid || alloc_src2_valid) ? S_REQ : S_READY;
      end
      if (req_valid && req_ready)
        st[req_idx] <= S_WAIT;
      if (rsp_valid && !rsp_block) begin
        if (rsp_ok) begin
          if (rsp_src) begin
            data2_q[rsp_ent] <= rsp_data;
            got2_q[rsp_ent]  <= 1'b1;
          end else begin
            data1_q[rsp_ent] <= rsp_data;
            got1_q[rsp_ent]  <= 1'b1;
          end
          if (rsp_done)
            st[rsp_ent] <= S_READY;
        end else begin
          rsp_err <= 1'b1;
        end
      end
      if (disp_valid && disp_ready) begin
        st[disp_idx]     <= S_FREE;
        got1_q[disp_idx] <= 1'b0;
        got2_q[disp_idx] <= 1'b0;
        rr_ptr           <= disp_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_oc_collector.sv
// tb/tb_oc_collector.sv - scoreboard bench for oc_collector
// Requests and dispatches are queued when stimulus is driven and popped by negedge monitors.
module tb_oc_collector;

  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_ready;
  logic [2:0]    alloc_warp;
  logic          alloc_src1_valid, alloc_src2_valid;
  logic [2:0]    alloc_src1_row, alloc_src2_row, alloc_dst_row;
  logic          req_valid, req_ready, req_2op, req_src1_valid, req_src2_valid;
  logic [2:0]    req_src1_row, req_src2_row, req_src1_tag, req_src2_tag;
  logic          rsp_valid;
  logic [2:0]    rsp_tag;
  logic [DW-1:0] rsp_data;
  logic          disp_valid, disp_ready;
  logic [1:0]    disp_ocid;
  logic [2:0]    disp_warp, disp_dst_row;
  logic [DW-1:0] disp_src1_data, disp_src2_data;
  logic          rsp_err;

  oc_collector #(.DW(DW), .NUM_OC(4), .ROW_W(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_warp(alloc_warp),
    .alloc_src1_valid(alloc_src1_valid), .alloc_src2_valid(alloc_src2_valid),
    .alloc_src1_row(alloc_src1_row), .alloc_src2_row(alloc_src2_row),
    .alloc_dst_row(alloc_dst_row),
    .req_valid(req_valid), .req_ready(req_ready), .req_2op(req_2op),
    .req_src1_valid(req_src1_valid), .req_src2_valid(req_src2_valid),
    .req_src1_row(req_src1_row), .req_src2_row(req_src2_row),
    .req_src1_tag(req_src1_tag), .req_src2_tag(req_src2_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ocid(disp_ocid),
    .disp_warp(disp_warp), .disp_dst_row(disp_dst_row),
    .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v1, v2;
    logic [2:0] r1, r2, t1, t2;
  } req_exp_t;

  typedef struct {
    logic [1:0]    ocid;
    logic [2:0]    warp, dst;
    logic [DW-1:0] d1, d2;
  } disp_exp_t;

  req_exp_t  req_q[$];
  disp_exp_t disp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] DATA_A = {8{32'hA5A5_0001}};
  localparam logic [DW-1:0] DATA_B = {8{32'h5A5A_0002}};
  localparam logic [DW-1:0] DATA_C = {8{32'hC0DE_0003}};

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic do_alloc(input logic [2:0] w, input logic v1, input logic [2:0] r1,
                          input logic v2, input logic [2:0] r2, input logic [2:0] d);
    alloc_valid      = 1'b1;
    alloc_warp       = w;
    alloc_src1_valid = v1;
    alloc_src1_row   = r1;
    alloc_src2_valid = v2;
    alloc_src2_row   = r2;
    alloc_dst_row    = d;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic push_req(input logic [1:0] e, input logic v1, input logic [2:0] r1,
                          input logic v2, input logic [2:0] r2);
    req_exp_t x;
    x.v1 = v1;
    x.v2 = v2;
    x.r1 = v1 ? r1 : 3'd0;
    x.r2 = v2 ? r2 : 3'd0;
    x.t1 = v1 ? {1'b0, e} : 3'd0;
    x.t2 = v2 ? {1'b1, e} : 3'd0;
    req_q.push_back(x);
  endtask

  task automatic push_disp(input logic [1:0] e, input logic [2:0] w, input logic [2:0] d,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    disp_exp_t x;
    x.ocid = e;
    x.warp = w;
    x.dst  = d;
    x.d1   = d1;
    x.d2   = d2;
    disp_q.push_back(x);
  endtask

  task automatic send_rsp(input logic [2:0] tag, input logic [DW-1:0] data);
    rsp_valid = 1'b1;
    rsp_tag   = tag;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && req_valid && req_ready) begin
      if (req_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        req_exp_t e;
        e = req_q.pop_front();
        chk("req_v1", req_src1_valid, e.v1);
        chk("req_v2", req_src2_valid, e.v2);
        chk("req_2op", req_2op, e.v1 & e.v2);
        chk("req_r1", req_src1_row, e.r1);
        chk("req_r2", req_src2_row, e.r2);
        chk("req_t1", req_src1_tag, e.t1);
        chk("req_t2", req_src2_tag, e.t2);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && disp_valid && disp_ready) begin
      if (disp_q.size() == 0) chk("disp_unexpected", 1, 0);
      else begin
        disp_exp_t e;
        e = disp_q.pop_front();
        chk("disp_ocid", disp_ocid, e.ocid);
        chk("disp_warp", disp_warp, e.warp);
        chk("disp_dst", disp_dst_row, e.dst);
        chk("disp_d1", disp_src1_data, e.d1);
        chk("disp_d2", disp_src2_data, e.d2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; alloc_valid = 1'b0; alloc_warp = '0;
    alloc_src1_valid = 1'b0; alloc_src2_valid = 1'b0;
    alloc_src1_row = '0; alloc_src2_row = '0; alloc_dst_row = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_tag = '0; rsp_data = '0; disp_ready = 1'b0;

    do_reset();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_disp_d1", disp_src1_data, 0);

    // Two-operand instruction end to end
    req_ready = 1'b1; disp_ready = 1'b1;
    push_req(2'd0, 1, 3'd3, 1, 3'd5);
    push_disp(2'd0, 3'd2, 3'd1, DATA_A, DATA_B);
    do_alloc(3'd2, 1, 3'd3, 1, 3'd5, 3'd1);
    chk("t1_req_valid", req_valid, 1);
    chk("t1_req_2op", req_2op, 1);
    chk("t1_tag2", req_src2_tag, 3'b100);
    tick();
    chk("t1_req_done", req_valid, 0);
    send_rsp(3'b000, DATA_A);
    chk("t1_no_disp_early", disp_valid, 0);
    send_rsp(3'b100, DATA_B);
    chk("t1_disp_valid", disp_valid, 1);
    chk("t1_alloc_ready", alloc_ready, 1);
    tick();
    chk("t1_disp_gone", disp_valid, 0);

    // Only src2 used; src1 data must read back as zero
    push_req(2'd0, 0, 3'd0, 1, 3'd6);
    push_disp(2'd0, 3'd5, 3'd4, '0, DATA_C);
    do_alloc(3'd5, 0, 3'd0, 1, 3'd6, 3'd4);
    chk("t3_req_v1", req_src1_valid, 0);
    chk("t3_req_2op", req_2op, 0);
    tick();
    send_rsp(3'b100, DATA_C);
    chk("t3_disp_valid", disp_valid, 1);
    chk("t3_d1_zero", disp_src1_data, 0);
    tick();
    chk("t3_rsp_err", rsp_err, 0);

    // Fill all entries with source-less instructions, then drain in order
    disp_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_disp(2'(i), 3'(i), 3'(7 - i), '0, '0);
      do_alloc(3'(i), 0, 3'd0, 0, 3'd0, 3'(7 - i));
    end
    chk("t4_full", alloc_ready, 0);
    chk("t4_no_req", req_valid, 0);
    chk("t4_disp_first", disp_ocid, 0);
    disp_ready = 1'b1;
    repeat (4) tick();
    chk("t4_drained", disp_valid, 0);
    chk("t4_alloc_ready", alloc_ready, 1);

    // Request backpressure with two entries waiting to issue
    req_ready = 1'b0;
    do_reset();
    push_req(2'd0, 1, 3'd1, 1, 3'd2);
    do_alloc(3'd1, 1, 3'd1, 1, 3'd2, 3'd0);
    push_req(2'd1, 1, 3'd3, 1, 3'd4);
    do_alloc(3'd3, 1, 3'd3, 1, 3'd4, 3'd0);
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_valid", req_valid, 1);
      chk("t5_hold_tag", req_src1_tag, 3'b000);
      chk("t5_hold_row", req_src2_row, 3'd2);
      tick();
    end
    req_ready = 1'b1;
    tick();
    chk("t5_second_tag", req_src1_tag, 3'b001);
    tick();
    chk("t5_req_idle", req_valid, 0);

    // Responses in the first cycle after reset release are ignored silently
    do_reset();
    send_rsp(3'b010, DATA_A);
    chk("t6_blocked", rsp_err, 0);

    // Stray response to a FREE entry sets the sticky error
    send_rsp(3'b010, DATA_A);
    chk("t6_err_set", rsp_err, 1);
    chk("t6_no_disp", disp_valid, 0);
    chk("t6_still_free", alloc_ready, 1);
    repeat (3) tick();
    chk("t6_err_sticky", rsp_err, 1);
    rst = 1'b0;
    tick();
    chk("t6_err_cleared", rsp_err, 0);
    rst = 1'b1;
    tick();

    chk("req_q_empty", req_q.size(), 0);
    chk("disp_q_empty", disp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
